// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a persistent carry flag, valid/ready handshakes
// and N-cycle shift-add multiply / restoring divide.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, op, data_a, data_b,
//        out_valid/out_ready, S, zero, carry_out (carry flag, also carry-in).
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] data_a,
  input  logic [N-1:0] data_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         zero,
  output logic         carry_out
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_div;
  logic [N-1:0]   r_hi;
  logic [N-1:0]   r_lo;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_s;
  logic           r_zero;
  logic           r_carry;

  logic [N:0]     w_sum;
  logic [N-1:0]   w_res;
  logic           w_c;
  logic           w_iter;

  logic [N:0]     w_madd;
  logic [N:0]     w_shf;
  logic           w_ge;
  logic [N-1:0]   w_rem;
  logic [N-1:0]   w_nhi;
  logic [N-1:0]   w_nlo;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign S         = r_s;
  assign zero      = r_zero;
  assign carry_out = r_carry;

  assign w_iter = (op == 4'd10) || (op == 4'd11);

  // Single-cycle datapath, evaluated on the inputs at the accept edge.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    case (op)
      4'd0: begin
        w_sum = {1'b0, data_a} + {1'b0, data_b}
              + {{N{1'b0}}, r_carry};
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
      end
      4'd1: begin
        // carry flag acts as borrow-in
        w_sum = {1'b0, data_a} + {1'b0, ~data_b}
              + {{N{1'b0}}, ~r_carry};
        w_res = w_sum[N-1:0];
        w_c   = ~w_sum[N];
      end
      4'd2: begin
        w_sum = {1'b0, data_a} + {1'b0, data_b};
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
      end
      4'd3: begin
        w_sum = {1'b0, data_a} + {1'b0, ~data_b}
              + {{N{1'b0}}, 1'b1};
        w_res = w_sum[N-1:0];
        w_c   = ~w_sum[N];
      end
      4'd4: w_res = data_a & data_b;
      4'd5: w_res = data_a | data_b;
      4'd6: w_res = {{(N-1){1'b0}}, (data_a < data_b)};
      4'd7: w_res = data_a ^ data_b;
      4'd8: begin
        w_res = {data_a[N-2:0], 1'b0};
        w_c   = data_a[N-1];
      end
      4'd9: begin
        w_res = {1'b0, data_a[N-1:1]};
        w_c   = data_a[0];
      end
      default: begin
        w_res = '0;
        w_c   = 1'b0;
      end
    endcase
  end

  // One iteration step. MUL: {hi,lo} holds partial product / multiplier.
  // DIV: hi is the remainder, lo shifts the dividend out and quotient in.
  assign w_madd = {1'b0, r_hi}
                + (r_lo[0] ? {1'b0, r_b} : {(N+1){1'b0}});
  assign w_shf  = {r_hi, r_lo[N-1]};
  assign w_ge   = (w_shf >= {1'b0, r_b});
  // remainder stays below divisor, so the low N bits are exact
  assign w_rem  = w_shf[N-1:0] - r_b;

  always_comb begin
    if (r_div) begin
      w_nhi = w_ge ? w_rem : w_shf[N-1:0];
      w_nlo = {r_lo[N-2:0], w_ge};
    end else begin
      w_nhi = w_madd[N:1];
      w_nlo = {w_madd[0], r_lo[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_iter) begin
              r_state <= BUSY;
              r_cnt   <= CW'(N - 1);
              r_div   <= (op == 4'd11);
              r_hi    <= '0;
              r_lo    <= data_a;
              r_b     <= data_b;
            end else begin
              r_state <= DONE;
              r_s     <= w_res;
              r_zero  <= ~|w_res;
              r_carry <= w_c;
            end
          end
        end
        BUSY: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_s     <= w_nlo;
            r_zero  <= ~|w_nlo;
            // divide-by-zero flags carry; MUL flags high-half overflow
            r_carry <= r_div ? (r_b == '0) : (|w_nhi);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (N=8).
// Inputs change on the falling edge; outputs are sampled 1ns after rising.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] S;
  logic       zero;
  logic       carry_out;

  int n_cmp;
  int n_err;

  alu_seq #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_a    (data_a),
    .data_b    (data_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .zero      (zero),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o,
                       input logic [7:0] a,
                       input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    data_a   = a;
    data_b   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_a   = 8'h00;
    data_b   = 8'h00;
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "/ovld0"}, 32'(out_valid), 32'd0);
    chk({tag, "/irdy1"}, 32'(in_ready), 32'd1);
  endtask

  // lat = rising edges after the accept edge until out_valid
  task automatic run(input string tag,
                     input logic [3:0] o,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [7:0] es,
                     input logic ec,
                     input int elat);
    int cyc;
    issue(o, a, b);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "/lat"}, 32'(cyc), 32'(elat));
    chk({tag, "/S"}, 32'(S), 32'(es));
    chk({tag, "/zero"}, 32'(zero), 32'(es == 8'h00));
    chk({tag, "/carry"}, 32'(carry_out), 32'(ec));
    handshake(tag);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    op        = 4'd2;
    data_a    = 8'hFF;
    data_b    = 8'h01;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst/irdy", 32'(in_ready), 32'd1);
    chk("rst/ovld", 32'(out_valid), 32'd0);
    chk("rst/S", 32'(S), 32'd0);
    chk("rst/zero", 32'(zero), 32'd1);
    chk("rst/carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst/nocap", 32'(out_valid), 32'd0);

    run("addx", 4'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 0);
    run("add",  4'd0, 8'h00, 8'h00, 8'h01, 1'b0, 0);
    run("subx", 4'd3, 8'h00, 8'h01, 8'hFF, 1'b1, 0);
    run("sub",  4'd1, 8'h05, 8'h02, 8'h02, 1'b0, 0);
    run("and",  4'd4, 8'hF0, 8'h3C, 8'h30, 1'b0, 0);
    run("or",   4'd5, 8'hF0, 8'h3C, 8'hFC, 1'b0, 0);
    run("mul",  4'd10, 8'h10, 8'h20, 8'h00, 1'b1, 8);
    run("mul2", 4'd10, 8'h0D, 8'h0B, 8'h8F, 1'b0, 8);
    run("div",  4'd11, 8'hC8, 8'h07, 8'h1C, 1'b0, 8);
    run("div0", 4'd11, 8'h42, 8'h00, 8'hFF, 1'b1, 8);

    // backpressure: result must stay put, new requests ignored
    issue(4'd6, 8'h03, 8'h04);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        @(negedge clk);
        in_valid = 1'b1;
        op       = 4'd7;
        data_a   = 8'hA5;
        data_b   = 8'h0F;
        @(posedge clk);
        #1;
      end else if (i > 0) begin
        @(posedge clk);
        #1;
      end
      chk("bp/ovld", 32'(out_valid), 32'd1);
      chk("bp/S", 32'(S), 32'h01);
      chk("bp/irdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake("bp");
    @(posedge clk);
    #1;
    chk("bp/nocap", 32'(out_valid), 32'd0);
    chk("bp/Skeep", 32'(S), 32'h01);

    // reset in the middle of a multiply
    issue(4'd10, 8'h10, 8'h20);
    repeat (2) @(posedge clk);
    #1;
    chk("rmul/busy", 32'(in_ready), 32'd0);
    chk("rmul/Shold", 32'(S), 32'h01);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rmul/irdy", 32'(in_ready), 32'd1);
    chk("rmul/ovld", 32'(out_valid), 32'd0);
    chk("rmul/S", 32'(S), 32'd0);
    chk("rmul/carry", 32'(carry_out), 32'd0);
    run("xor", 4'd7, 8'hA5, 8'h0F, 8'hAA, 1'b0, 0);

    run("shl",  4'd8, 8'h81, 8'h00, 8'h02, 1'b1, 0);
    run("shr",  4'd9, 8'h81, 8'h00, 8'h40, 1'b1, 0);
    run("op13", 4'd13, 8'hFF, 8'hFF, 8'h00, 1'b0, 0);
    run("less0", 4'd6, 8'h04, 8'h03, 8'h00, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
